hazard_ctrl_unit: RTL and testbench

- Next-generation hazard/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Combinationally selects per-operand forwarding sources from E, M and W.
- Sequences load-use stalls of configurable length and stalls for a multi-cycle MUL/DIV unit (HI/LO).
- Stall/flush controls are registered on the falling clock edge, so the pipeline registers sample them at the next rising edge.

---
 rtl/hazard_ctrl_unit_pkg.sv | 19 +
 rtl/hazard_ctrl_unit_if.sv | 46 ++++
 rtl/hazard_ctrl_unit_fwd_sel.sv | 34 +++
 rtl/hazard_ctrl_unit.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared encodings for the hazard/forwarding controller: forwarding selects,
// load-stall FSM states and the default register-address width.
package hazard_ctrl_unit_pkg;

    localparam int AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_E    = 2'd1,
        FWD_M    = 2'd2,
        FWD_W    = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        IDLE       = 1'b0,
        LOAD_STALL = 1'b1
    } load_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline datapath,
// slave is the hazard controller.
interface hazard_ctrl_unit_if
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int AW = AW_DEFAULT
);

    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic          d_read_rs;
    logic          d_read_rt;
    logic          d_read_hilo;
    logic          d_mdu_op;
    logic [AW-1:0] e_rw;
    logic [AW-1:0] m_rw;
    logic [AW-1:0] w_rw;
    logic          e_regwrite;
    logic          m_regwrite;
    logic          w_regwrite;
    logic          e_load;
    logic          e_mdu_start;
    logic          e_branch_taken;
    logic [1:0]    fwd_rs;
    logic [1:0]    fwd_rt;
    logic          stall_f;
    logic          stall_d;
    logic          flush_d;
    logic          flush_e;
    logic          mdu_busy;

    modport master (
        output d_rs, d_rt, d_read_rs, d_read_rt, d_read_hilo, d_mdu_op,
        output e_rw, m_rw, w_rw, e_regwrite, m_regwrite, w_regwrite,
        output e_load, e_mdu_start, e_branch_taken,
        input  fwd_rs, fwd_rt, stall_f, stall_d, flush_d, flush_e, mdu_busy
    );

    modport slave (
        input  d_rs, d_rt, d_read_rs, d_read_rt, d_read_hilo, d_mdu_op,
        input  e_rw, m_rw, w_rw, e_regwrite, m_regwrite, w_regwrite,
        input  e_load, e_mdu_start, e_branch_taken,
        output fwd_rs, fwd_rt, stall_f, stall_d, flush_d, flush_e, mdu_busy
    );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_sel.sv
// Per-operand forwarding source select: nearest producing stage wins (E > M > W),
// register $0 never forwards.
module hazard_ctrl_unit_fwd_sel
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic [AW-1:0] i_src,
    input  logic          i_read,
    input  logic [AW-1:0] i_e_rw,
    input  logic          i_e_regwrite,
    input  logic [AW-1:0] i_m_rw,
    input  logic          i_m_regwrite,
    input  logic [AW-1:0] i_w_rw,
    input  logic          i_w_regwrite,
    output fwd_sel_e      o_sel
);

    logic w_src_live;

    assign w_src_live = i_read && (i_src != '0);

    always_comb begin
        o_sel = FWD_NONE;
        if (w_src_live && i_e_regwrite && (i_src == i_e_rw)) begin
            o_sel = FWD_E;
        end else if (w_src_live && i_m_regwrite && (i_src == i_m_rw)) begin
            o_sel = FWD_M;
        end else if (w_src_live && i_w_regwrite && (i_src == i_w_rw)) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: combinational forwarding,
// load-use and MUL/DIV stall sequencing, branch flush; controls registered on negedge.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 32,
    parameter int CW       = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_unit_if.slave  io_hz
);

    fwd_sel_e    w_fwd_rs;
    fwd_sel_e    w_fwd_rt;
    logic        w_lu_haz;
    logic        w_mdu_haz;
    logic        w_ld_stall;
    logic        w_stall;
    logic        w_flush_d;
    logic        w_flush_e;
    load_state_e r_state;
    load_state_e w_state_nxt;
    logic [CW-1:0] r_ld_cnt;
    logic [CW-1:0] w_ld_cnt_nxt;
    logic [CW-1:0] r_mdu_cnt;
    logic [CW-1:0] w_mdu_cnt_nxt;
    logic        r_stall;
    logic        r_flush_d;
    logic        r_flush_e;
    logic        r_mdu_busy;

    hazard_ctrl_unit_fwd_sel #(.AW(AW)) u_fwd_rs (
        .i_src        (io_hz.d_rs),
        .i_read       (io_hz.d_read_rs),
        .i_e_rw       (io_hz.e_rw),
        .i_e_regwrite (io_hz.e_regwrite),
        .i_m_rw       (io_hz.m_rw),
        .i_m_regwrite (io_hz.m_regwrite),
        .i_w_rw       (io_hz.w_rw),
        .i_w_regwrite (io_hz.w_regwrite),
        .o_sel        (w_fwd_rs)
    );

    hazard_ctrl_unit_fwd_sel #(.AW(AW)) u_fwd_rt (
        .i_src        (io_hz.d_rt),
        .i_read       (io_hz.d_read_rt),
        .i_e_rw       (io_hz.e_rw),
        .i_e_regwrite (io_hz.e_regwrite),
        .i_m_rw       (io_hz.m_rw),
        .i_m_regwrite (io_hz.m_regwrite),
        .i_w_rw       (io_hz.w_rw),
        .i_w_regwrite (io_hz.w_regwrite),
        .o_sel        (w_fwd_rt)
    );

    // E is the highest-priority source, so an FWD_E select is exactly "E matches".
    assign w_lu_haz  = io_hz.e_load && ((w_fwd_rs == FWD_E) || (w_fwd_rt == FWD_E));
    assign w_mdu_haz = r_mdu_busy && (io_hz.d_read_hilo || io_hz.d_mdu_op);

    always_comb begin
        w_state_nxt   = r_state;
        w_ld_cnt_nxt  = r_ld_cnt;
        w_mdu_cnt_nxt = r_mdu_cnt;
        case (r_state)
            IDLE: begin
                if (w_lu_haz && !io_hz.e_branch_taken) begin
                    w_state_nxt  = LOAD_STALL;
                    w_ld_cnt_nxt = CW'(LOAD_LAT - 1);
                end
            end
            LOAD_STALL: begin
                if (r_ld_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_ld_cnt_nxt = r_ld_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (io_hz.e_mdu_start) begin
            w_mdu_cnt_nxt = CW'(MDU_LAT);
        end else if (r_mdu_cnt != '0) begin
            w_mdu_cnt_nxt = r_mdu_cnt - CW'(1);
        end

        // Controls reflect the state being entered so the stall lands on the next rising edge.
        w_ld_stall = (w_state_nxt == LOAD_STALL);
        w_stall    = (w_ld_stall || w_mdu_haz) && !io_hz.e_branch_taken;
        w_flush_d  = io_hz.e_branch_taken;
        w_flush_e  = w_ld_stall || w_mdu_haz || io_hz.e_branch_taken;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ld_cnt   <= '0;
            r_mdu_cnt  <= '0;
            r_stall    <= 1'b0;
            r_flush_d  <= 1'b0;
            r_flush_e  <= 1'b0;
            r_mdu_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ld_cnt   <= w_ld_cnt_nxt;
            r_mdu_cnt  <= w_mdu_cnt_nxt;
            r_stall    <= w_stall;
            r_flush_d  <= w_flush_d;
            r_flush_e  <= w_flush_e;
            r_mdu_busy <= (w_mdu_cnt_nxt != '0);
        end
    end

    assign io_hz.fwd_rs   = w_fwd_rs;
    assign io_hz.fwd_rt   = w_fwd_rt;
    assign io_hz.stall_f  = r_stall;
    assign io_hz.stall_d  = r_stall;
    assign io_hz.flush_d  = r_flush_d;
    assign io_hz.flush_e  = r_flush_e;
    assign io_hz.mdu_busy = r_mdu_busy;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit (LOAD_LAT=3, MDU_LAT=4): expected outputs are
// queued as each cycle's stimulus is driven and compared after the capturing negedge.
module tb_hazard_ctrl_unit;
    import hazard_ctrl_unit_pkg::*;

    typedef struct packed {
        logic [1:0] fr;
        logic [1:0] ft;
        logic       st;
        logic       fd;
        logic       fe;
        logic       mb;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t  sb_q[$];
    string tag_q[$];

    hazard_ctrl_unit_if #(.AW(5)) hz ();

    hazard_ctrl_unit #(
        .AW(5), .LOAD_LAT(3), .MDU_LAT(4), .CW(6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_hz (hz)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] fr, input logic [1:0] ft, input logic st,
                                input logic fd, input logic fe, input logic mb);
        exp_t e;
        e.fr = fr; e.ft = ft; e.st = st; e.fd = fd; e.fe = fe; e.mb = mb;
        return e;
    endfunction

    task automatic set_idle();
        hz.d_rs = '0; hz.d_rt = '0; hz.d_read_rs = 0; hz.d_read_rt = 0;
        hz.d_read_hilo = 0; hz.d_mdu_op = 0;
        hz.e_rw = '0; hz.m_rw = '0; hz.w_rw = '0;
        hz.e_regwrite = 0; hz.m_regwrite = 0; hz.w_regwrite = 0;
        hz.e_load = 0; hz.e_mdu_start = 0; hz.e_branch_taken = 0;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, ".stall_f"}, hz.stall_f, 0);
        check_val({tag, ".stall_d"}, hz.stall_d, 0);
        check_val({tag, ".flush_d"}, hz.flush_d, 0);
        check_val({tag, ".flush_e"}, hz.flush_e, 0);
        check_val({tag, ".mdu_busy"}, hz.mdu_busy, 0);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step(input string tag, input exp_t e);
        exp_t  x;
        string t;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        #1;
        x = sb_q.pop_front();
        t = tag_q.pop_front();
        check_val({t, ".fwd_rs"},   hz.fwd_rs,   x.fr);
        check_val({t, ".fwd_rt"},   hz.fwd_rt,   x.ft);
        check_val({t, ".stall_f"},  hz.stall_f,  x.st);
        check_val({t, ".stall_d"},  hz.stall_d,  x.st);
        check_val({t, ".flush_d"},  hz.flush_d,  x.fd);
        check_val({t, ".flush_e"},  hz.flush_e,  x.fe);
        check_val({t, ".mdu_busy"}, hz.mdu_busy, x.mb);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load_use();
        set_idle();
        hz.e_load = 1; hz.e_rw = 5'd9; hz.e_regwrite = 1;
        hz.d_rt = 5'd9; hz.d_read_rt = 1;
    endtask

    // Dependent instruction held in D, bubble in E, load now in M.
    task automatic drive_load_held();
        set_idle();
        hz.d_rt = 5'd9; hz.d_read_rt = 1;
        hz.m_rw = 5'd9; hz.m_regwrite = 1;
    endtask

    initial begin
        set_idle();
        #1 rst_n = 1'b0;
        #2;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Forwarding priority and $0 suppression
        set_idle();
        hz.d_rs = 5'd8; hz.d_read_rs = 1;
        hz.e_rw = 5'd8; hz.m_rw = 5'd8; hz.w_rw = 5'd8;
        hz.e_regwrite = 1; hz.m_regwrite = 1; hz.w_regwrite = 1;
        hz.d_rt = 5'd8;
        step("fwd_e", mk(2'd1, 2'd0, 0, 0, 0, 0));
        hz.e_regwrite = 0;
        step("fwd_m", mk(2'd2, 2'd0, 0, 0, 0, 0));
        hz.m_regwrite = 0; hz.d_read_rt = 1;
        step("fwd_w", mk(2'd3, 2'd3, 0, 0, 0, 0));
        hz.e_regwrite = 1; hz.m_regwrite = 1; hz.d_rs = 5'd0;
        step("fwd_zero", mk(2'd0, 2'd1, 0, 0, 0, 0));

        // Load-use stall of exactly three cycles
        drive_load_use();
        step("lu_c0", mk(2'd0, 2'd1, 1, 0, 1, 0));
        drive_load_held();
        step("lu_c1", mk(2'd0, 2'd2, 1, 0, 1, 0));
        step("lu_c2", mk(2'd0, 2'd2, 1, 0, 1, 0));
        step("lu_c3", mk(2'd0, 2'd2, 0, 0, 0, 0));
        set_idle();
        step("lu_c4", mk(2'd0, 2'd0, 0, 0, 0, 0));

        // Taken branch beats the load-use hazard
        drive_load_use();
        hz.e_branch_taken = 1;
        step("br_c0", mk(2'd0, 2'd1, 0, 1, 1, 0));
        set_idle();
        step("br_c1", mk(2'd0, 2'd0, 0, 0, 0, 0));

        // MUL/DIV busy for four cycles, mfhi stalled, branch in the middle
        set_idle();
        hz.e_mdu_start = 1;
        step("mdu_c0", mk(2'd0, 2'd0, 0, 0, 0, 1));
        set_idle();
        hz.d_read_hilo = 1;
        step("mdu_c1", mk(2'd0, 2'd0, 1, 0, 1, 1));
        hz.e_branch_taken = 1;
        step("mdu_br", mk(2'd0, 2'd0, 0, 1, 1, 1));
        hz.e_branch_taken = 0;
        step("mdu_c3", mk(2'd0, 2'd0, 1, 0, 1, 1));
        step("mdu_c4", mk(2'd0, 2'd0, 1, 0, 1, 0));
        step("mdu_c5", mk(2'd0, 2'd0, 0, 0, 0, 0));
        set_idle();

        // Write to $0 never stalls or forwards
        hz.e_rw = 5'd0; hz.e_regwrite = 1; hz.e_load = 1;
        hz.d_rs = 5'd0; hz.d_read_rs = 1;
        step("r0_c0", mk(2'd0, 2'd0, 0, 0, 0, 0));
        set_idle();
        step("r0_c1", mk(2'd0, 2'd0, 0, 0, 0, 0));

        // Reset in the second cycle of a load stall
        drive_load_use();
        step("rm_c0", mk(2'd0, 2'd1, 1, 0, 1, 0));
        drive_load_held();
        step("rm_c1", mk(2'd0, 2'd2, 1, 0, 1, 0));
        check_val("rm_pre.stall_f", hz.stall_f, 1);
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst0", mk(2'd0, 2'd0, 0, 0, 0, 0));
        step("post_rst1", mk(2'd0, 2'd0, 0, 0, 0, 0));
        step("post_rst2", mk(2'd0, 2'd0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
